// File: rtl/video_out_align_port_if.sv
// Signal bundle for video_out_align_port.
// The slave side is the port itself; the master side is whoever drives timing and FIFO data.
interface video_out_align_port_if #(
   parameter int DSIZE = 24,
   parameter int LANES = 1
);
   logic [15:0]            vactive;
   logic [15:0]            hactive;
   logic                   in_vsync;
   logic                   in_hsync;
   logic                   in_de;
   logic [DSIZE*LANES-1:0] in_data;
   logic                   in_empty;
   logic                   rd_en;
   logic                   out_vsync;
   logic                   out_hsync;
   logic                   out_de;
   logic [DSIZE*LANES-1:0] odata;
   logic                   falign;
   logic                   lalign;
   logic                   ealign;
   logic                   underflow;
   logic                   hsize_err;
   logic [15:0]            line_cnt;

   modport master (
      output vactive, hactive, in_vsync, in_hsync, in_de, in_data, in_empty,
      input  rd_en, out_vsync, out_hsync, out_de, odata,
      input  falign, lalign, ealign, underflow, hsize_err, line_cnt
   );

   modport slave (
      input  vactive, hactive, in_vsync, in_hsync, in_de, in_data, in_empty,
      output rd_en, out_vsync, out_hsync, out_de, odata,
      output falign, lalign, ealign, underflow, hsize_err, line_cnt
   );
endinterface

// File: rtl/video_out_align_port.sv
// Video timing to FIFO read strobes, RD_LAT re-timing and frame/line/end alignment pulses.
// Define VIDEO_OUT_FILL_EN to replace beats read from an empty FIFO with FILL_VALUE.
module video_out_align_port #(
   parameter int                DSIZE      = 24,
   parameter int                LANES      = 1,
   parameter int                RD_LAT     = 1,
   parameter string             MODE       = "ONCE",
   parameter logic [DSIZE-1:0]  FILL_VALUE = '0
) (
   input  logic                 clock,
   input  logic                 rst_n,
   video_out_align_port_if.slave vif
);

   localparam logic [DSIZE*LANES-1:0] FILL_WORD = {LANES{FILL_VALUE}};

`ifdef VIDEO_OUT_FILL_EN
   localparam int PW = 4;
`else
   localparam int PW = 3;
`endif

   logic [PW-1:0] pipe_in;
   logic [PW-1:0] pipe_out;
   logic          fill_sel;
   logic          vsync_q_reg;
   logic          de_q_reg;
   logic          v_fall;
   logic          de_fall;
   logic          de_rise;
   logic [15:0]   line_cnt_reg;
   logic [15:0]   beat_cnt_reg;
   logic [17:0]   beat_px;
   logic          hsize_set;
   logic          under_set;
   logic          frame_blk_reg;
   logic          frame_blk_q_reg;
   logic          underflow_reg;
   logic          hsize_err_reg;

   assign vif.rd_en = vif.in_de;
   assign under_set = vif.in_de & vif.in_empty;

   // The empty mark rides the same pipe as de so the fill lands on the beat it belongs to.
`ifdef VIDEO_OUT_FILL_EN
   assign pipe_in  = {under_set, vif.in_vsync, vif.in_hsync, vif.in_de};
   assign fill_sel = pipe_out[3];
`else
   assign pipe_in  = {vif.in_vsync, vif.in_hsync, vif.in_de};
   assign fill_sel = 1'b0;
`endif

   genvar gi;
   generate
      if (RD_LAT == 0) begin : g_wire
         assign pipe_out = pipe_in;
      end else begin : g_pipe
         for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
            logic [PW-1:0] q_reg;
            if (gi == 0) begin : g_first
               always_ff @(posedge clock or negedge rst_n)
                  if (!rst_n) q_reg <= '0;
                  else        q_reg <= pipe_in;
            end else begin : g_next
               always_ff @(posedge clock or negedge rst_n)
                  if (!rst_n) q_reg <= '0;
                  else        q_reg <= g_stage[gi-1].q_reg;
            end
         end
         assign pipe_out = g_stage[RD_LAT-1].q_reg;
      end
   endgenerate

   assign vif.out_vsync = pipe_out[2];
   assign vif.out_hsync = pipe_out[1];
   assign vif.out_de    = pipe_out[0];
   assign vif.odata     = fill_sel ? FILL_WORD : vif.in_data;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q_reg <= 1'b0;
         de_q_reg    <= 1'b0;
      end else begin
         vsync_q_reg <= vif.in_vsync;
         de_q_reg    <= vif.in_de;
      end
   end

   assign v_fall     = vsync_q_reg & ~vif.in_vsync;
   assign de_fall    = de_q_reg & ~vif.in_de;
   assign de_rise    = ~de_q_reg & vif.in_de;
   assign vif.falign = v_fall;

   generate
      if (MODE == "LINE") begin : g_lalign_line
         assign vif.lalign = de_fall;
      end else if (MODE == "LINE_START") begin : g_lalign_start
         assign vif.lalign = de_rise;
      end else begin : g_lalign_once
         assign vif.lalign = 1'b0;
      end
   endgenerate

   // Frame start beats a coincident line end, so a new frame always starts at line 0.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)
         line_cnt_reg <= '0;
      else if (v_fall)
         line_cnt_reg <= '0;
      else if (de_fall && line_cnt_reg != 16'hFFFF)
         line_cnt_reg <= line_cnt_reg + 16'd1;
   end
   assign vif.line_cnt = line_cnt_reg;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         frame_blk_reg   <= 1'b0;
         frame_blk_q_reg <= 1'b0;
      end else begin
         frame_blk_reg   <= (line_cnt_reg == vif.vactive) && (vif.vactive != 16'd0);
         frame_blk_q_reg <= frame_blk_reg;
      end
   end
   assign vif.ealign = frame_blk_reg & ~frame_blk_q_reg;

   // The rising cycle is itself a beat, so the count restarts at one.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)
         beat_cnt_reg <= '0;
      else if (de_rise)
         beat_cnt_reg <= 16'd1;
      else if (vif.in_de && beat_cnt_reg != 16'hFFFF)
         beat_cnt_reg <= beat_cnt_reg + 16'd1;
   end

   assign beat_px   = 18'(beat_cnt_reg) * 18'(LANES);
   assign hsize_set = de_fall && (beat_px != {2'b00, vif.hactive});

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         underflow_reg <= 1'b0;
         hsize_err_reg <= 1'b0;
      end else begin
         if (under_set)   underflow_reg <= 1'b1;
         else if (v_fall) underflow_reg <= 1'b0;
         if (hsize_set)   hsize_err_reg <= 1'b1;
         else if (v_fall) hsize_err_reg <= 1'b0;
      end
   end
   assign vif.underflow = underflow_reg;
   assign vif.hsize_err = hsize_err_reg;

endmodule

// File: tb/tb_video_out_align_port.sv
// Directed bench for video_out_align_port: three instances (LINE/2 lanes/lat 2,
// LINE_START/1 lane/lat 1, ONCE/1 lane/lat 0) share one timing stream.
module tb_video_out_align_port;

   localparam logic [23:0] FILL = 24'h00FF00;

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   logic        vs = 1'b0, hs = 1'b0, de = 1'b0, emp = 1'b0;
   logic [23:0] pix = '0;
   logic [15:0] vact = 16'd3;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   always #5 clock = ~clock;

   video_out_align_port_if #(.DSIZE(24), .LANES(2)) ia ();
   video_out_align_port_if #(.DSIZE(24), .LANES(1)) ib ();
   video_out_align_port_if #(.DSIZE(24), .LANES(1)) ic ();

   assign ia.vactive = vact;  assign ib.vactive = vact;  assign ic.vactive = vact;
   assign ia.hactive = 16'd8; assign ib.hactive = 16'd4; assign ic.hactive = 16'd4;
   assign ia.in_vsync = vs;   assign ib.in_vsync = vs;   assign ic.in_vsync = vs;
   assign ia.in_hsync = hs;   assign ib.in_hsync = hs;   assign ic.in_hsync = hs;
   assign ia.in_de = de;      assign ib.in_de = de;      assign ic.in_de = de;
   assign ia.in_empty = emp;  assign ib.in_empty = emp;  assign ic.in_empty = emp;
   assign ia.in_data = {pix, pix};
   assign ib.in_data = pix;
   assign ic.in_data = pix;

   video_out_align_port #(.DSIZE(24), .LANES(2), .RD_LAT(2), .MODE("LINE"), .FILL_VALUE(FILL))
      u_a (.clock(clock), .rst_n(rst_n), .vif(ia.slave));
   video_out_align_port #(.DSIZE(24), .LANES(1), .RD_LAT(1), .MODE("LINE_START"), .FILL_VALUE(FILL))
      u_b (.clock(clock), .rst_n(rst_n), .vif(ib.slave));
   video_out_align_port #(.DSIZE(24), .LANES(1), .RD_LAT(0), .MODE("ONCE"), .FILL_VALUE(FILL))
      u_c (.clock(clock), .rst_n(rst_n), .vif(ic.slave));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Drive one cycle's inputs just after the edge, then settle to mid-cycle for checks.
   task automatic cyc(input logic v, input logic h, input logic d, input logic e,
                      input logic [23:0] p);
      @(posedge clock);
      #1;
      vs = v; hs = h; de = d; emp = e; pix = p;
      #4;
   endtask

   // n beats of de, FIFO empty on beat eb, vsync level vb during beats and vf at the falling cycle.
   task automatic line(input int n, input int eb, input logic vb, input logic vf);
      logic [23:0] p;
      logic [23:0] exp_b, exp_c;
      logic [47:0] exp_a;
      $display("line: %0d beats, empty beat %0d, vsync %0b/%0b", n, eb, vb, vf);
      for (int b = 0; b < n; b++) begin
         p = 24'hA00000 | 24'(b);
         cyc(vb, 1'b0, 1'b1, (b == eb), p);
         exp_a = {p, p};
         exp_b = p;
         exp_c = p;
`ifdef VIDEO_OUT_FILL_EN
         if (b == eb + 2) exp_a = {FILL, FILL};
         if (b == eb + 1) exp_b = FILL;
         if (b == eb)     exp_c = FILL;
`endif
         chk("rd_en_beat", ia.rd_en, 1'b1);
         chk("odata_a", ia.odata, exp_a);
         chk("odata_b", ib.odata, exp_b);
         chk("odata_c", ic.odata, exp_c);
         chk("out_de_b", ib.out_de, b >= 1);
         chk("lalign_linestart", ib.lalign, b == 0);
         chk("lalign_line_beat", ia.lalign, 1'b0);
         chk("lalign_once", ic.lalign, 1'b0);
      end
      cyc(vf, 1'b0, 1'b0, 1'b0, 24'h0);
      chk("lalign_line_fall", ia.lalign, 1'b1);
      chk("lalign_linestart_fall", ib.lalign, 1'b0);
      chk("lalign_once_fall", ic.lalign, 1'b0);
   endtask

   initial begin
      // Reset with vsync held high: nothing may leak out.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
      chk("reset_flags_a", {ia.rd_en, ia.out_vsync, ia.out_hsync, ia.out_de, ia.falign,
                            ia.lalign, ia.ealign, ia.underflow, ia.hsize_err}, 9'h0);
      chk("reset_line_cnt_a", ia.line_cnt, 16'd0);
      chk("reset_odata_a", ia.odata, 48'h0);
      chk("reset_out_vsync_b", ib.out_vsync, 1'b0);
      rst_n = 1'b1;

      // Frame 1 start: vsync falls, out_vsync follows RD_LAT cycles later.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
      chk("falign_pulse", ia.falign, 1'b1);
      chk("out_vsync_a_t0", ia.out_vsync, 1'b1);
      chk("out_vsync_b_t0", ib.out_vsync, 1'b1);
      chk("out_vsync_c_t0", ic.out_vsync, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
      chk("falign_one_cycle", ia.falign, 1'b0);
      chk("out_vsync_a_t1", ia.out_vsync, 1'b1);
      chk("out_vsync_b_t1", ib.out_vsync, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
      chk("out_vsync_a_t2", ia.out_vsync, 1'b0);
      chk("line_cnt_frame_start", ia.line_cnt, 16'd0);

      // Three correct lines, vactive=3.
      line(4, 99, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
      chk("line_cnt_1", ia.line_cnt, 16'd1);
      chk("hsize_ok_1", ia.hsize_err, 1'b0);
      line(4, 99, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
      chk("line_cnt_2", ia.line_cnt, 16'd2);
      line(4, 99, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
      chk("line_cnt_3", ia.line_cnt, 16'd3);
      chk("ealign_early", ia.ealign, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
      chk("ealign_a", ia.ealign, 1'b1);
      chk("ealign_b", ib.ealign, 1'b1);
      chk("ealign_c", ic.ealign, 1'b1);
      chk("hsize_frame1", ia.hsize_err, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
      chk("ealign_one_cycle", ia.ealign, 1'b0);

      // Frame 2: underflow on beat 3 of line 1, 5-beat line 2.
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
      chk("falign_frame2", ia.falign, 1'b1);
      chk("out_hsync_b", ib.out_hsync, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
      chk("line_cnt_cleared", ia.line_cnt, 16'd0);
      line(4, 2, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
      chk("underflow_set", ia.underflow, 1'b1);
      chk("hsize_ok_f2l1", ia.hsize_err, 1'b0);
      line(5, 99, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
      chk("hsize_err_set", ia.hsize_err, 1'b1);
      chk("line_cnt_f2l2", ia.line_cnt, 16'd2);
      line(4, 99, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
      chk("hsize_err_sticky", ia.hsize_err, 1'b1);
      chk("underflow_sticky", ia.underflow, 1'b1);
      chk("line_cnt_f2l3", ia.line_cnt, 16'd3);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);

      // falign coincident with a bad line's de falling: count goes to 0, set beats clear.
      line(5, 99, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
      chk("coincide_line_cnt", ia.line_cnt, 16'd0);
      chk("coincide_hsize_set_wins", ia.hsize_err, 1'b1);
      chk("coincide_underflow_clr", ia.underflow, 1'b0);
      chk("coincide_no_ealign0", ia.ealign, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
      chk("coincide_no_ealign1", ia.ealign, 1'b0);

      // Plain falign clears hsize_err.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
      chk("hsize_err_cleared", ia.hsize_err, 1'b0);

      // vactive=0 never produces ealign.
      vact = 16'd0;
      for (int l = 0; l < 3; l++) begin
         line(4, 99, 1'b0, 1'b0);
         for (int g = 0; g < 3; g++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
            chk("vactive0_no_ealign", ia.ealign, 1'b0);
         end
      end
      chk("vactive0_line_cnt", ia.line_cnt, 16'd3);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/video_out_align_port.md
Name: video_out_align_port

Overview:
- Parametrised successor to the single-pixel native output port on the VDMA read side.
- Turns an external video timing stream (vsync/hsync/de) into FIFO read strobes and frame/line/end alignment pulses for the read-DMA controller.
- Re-times the timing signals to match a configurable FIFO read latency and packs LANES pixels per beat.
- Adds line-length checking, line counting with end-of-frame detection, and underflow monitoring.

Parameters:
DSIZE, 24, bits per pixel
LANES, 1, pixels per clock beat (1, 2 or 4)
RD_LAT, 1, FIFO read-data latency in cycles (0..3); timing outputs are delayed by this amount
MODE, "ONCE", "ONCE": no line alignment; "LINE": lalign on de falling; "LINE_START": lalign on de rising
FILL_VALUE, 0, pixel value substituted on underflow (used only with the optional feature)

Ports:
clock  in  1  system clock
rst_n  in  1  asynchronous active-low reset
vactive  in  16  active lines per frame
hactive  in  16  active pixels per line (must be a multiple of LANES)
in_vsync  in  1  timing vsync, active high
in_hsync  in  1  timing hsync
in_de  in  1  timing data enable (one beat = LANES pixels)
in_data  in  DSIZE*LANES  FIFO read data
in_empty  in  1  FIFO empty flag
rd_en  out  1  FIFO read strobe
out_vsync  out  1  vsync delayed RD_LAT cycles
out_hsync  out  1  hsync delayed RD_LAT cycles
out_de  out  1  de delayed RD_LAT cycles
odata  out  DSIZE*LANES  pixel data aligned with out_de
falign  out  1  frame-align pulse
lalign  out  1  line-align pulse
ealign  out  1  end-of-frame pulse
underflow  out  1  sticky: read attempted while FIFO empty
hsize_err  out  1  sticky: line beat count mismatch
line_cnt  out  16  current line count

Behaviour:
- Reset: every register clears. All outputs are 0; out_* are 0 for the full delay line.
- rd_en = in_de, combinational, so there is zero latency to the FIFO.
- Timing delay:
  - {vsync, hsync, de} pass through an RD_LAT-stage register pipe.
  - RD_LAT=0 is a direct wire.
  - odata = in_data, combinational.
- Edge detection:
  - in_vsync and in_de are each registered once (q).
  - falling = q & ~in; rising = ~q & in.
  - Each is a one-cycle pulse in the cycle the new level is first seen.
- Alignment pulses:
  - falign = vsync falling.
  - lalign = 0 in "ONCE", de falling in "LINE", de rising in "LINE_START".
- Line counter:
  - Clears on falign.
  - Otherwise increments on de falling in every MODE.
  - Saturates at 16'hFFFF.
  - If falign and de falling coincide, falign wins and the count becomes 0.
  - Drives line_cnt.
- End of frame:
  - frame_blk is registered as (line_cnt == vactive) && (vactive != 0).
  - ealign is the one-cycle rising pulse of frame_blk, two cycles after the final de falling.
  - vactive=0 never produces ealign.
  - A falign between frames drops frame_blk, which re-arms ealign.
- Beat counter:
  - Clears on de rising and increments each de cycle.
  - At de falling, hsize_err sets if beats*LANES != hactive.
  - Comparison is done at 18 bits; the counter saturates at 16'hFFFF.
- Underflow: sets when rd_en & in_empty.
- underflow and hsize_err are sticky and clear on falign. If a clear and a set coincide, the set wins.
- Reset asserted mid-frame: counters and flags clear immediately. The first falign after release restarts normally; ealign is suppressed until line_cnt next reaches vactive.

Optional Feature:
- Macro: VIDEO_OUT_FILL_EN.
- Defined:
  - A one-bit empty-mark (rd_en & in_empty) travels through the same RD_LAT pipe as de.
  - When the mark emerges, odata = {LANES{FILL_VALUE}}; otherwise odata = in_data.
  - With RD_LAT=0 the substitution is combinational.
- Undefined: odata = in_data always. The underflow flag still operates.

Test Plan:
1. Reset, then RD_LAT=2, vsync high→low -> falign pulses 1 cycle; out_vsync falls exactly 2 cycles after in_vsync; all outputs 0 during reset.
2. MODE="LINE", LANES=2, hactive=8, vactive=3, three de bursts of 4 beats -> lalign pulses 3 times; line_cnt 1,2,3; ealign once, 2 cycles after the 3rd de falling; hsize_err=0.
3. Same setup, second line carries 5 beats -> hsize_err sets at that de falling, stays set, clears on next falign.
4. in_empty=1 during beat 3 of a line, VIDEO_OUT_FILL_EN defined, FILL_VALUE=24'h00FF00, RD_LAT=1 -> underflow sets; odata = FILL_VALUE on the out_de beat 1 cycle later, other beats pass in_data.
5. falign coincident with de falling -> line_cnt=0, no increment; vactive=0 -> no ealign over a full frame.
6. MODE="ONCE" and MODE="LINE_START" -> lalign stays 0 in ONCE; pulses on each de rising in LINE_START.
